parity_frame_checker: RTL and testbench
=======================================

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data word width in bits.
REQ-002 SHALL have parameter LEN_W, default 8: width of the frame beat counter.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 SHALL have one clock and an asynchronous active-low reset, exactly as follows:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
REQ-005 SHALL have the remaining ports:
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block accepts a word.
- in_data  input  DATA_W  data word.
- in_par  input  1  parity bit sent with in_data by the generator.
- in_last  input  1  marks the final word of a frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_and  output  1  AND reduction over all bits of all frame words.
- out_or  output  1  OR reduction over all bits of all frame words.
- out_xor  output  1  XOR reduction over all bits of all frame words.
- out_par_err  output  1  at least one word in the frame failed its parity check.
- out_len  output  LEN_W  number of words accepted in the frame, saturating.
- err_cnt  output  16  count of frames with parity errors; present only under the macro in REQ-019.

Function
REQ-006 SHALL implement the states ACCUM and REPORT, and SHALL enter ACCUM on reset.
REQ-007 in ACCUM: in_ready=1, out_valid=0. In REPORT: in_ready=0, out_valid=1.
REQ-008 SHALL define a beat as a cycle where in_valid and in_ready are both 1; words outside a beat are ignored.
REQ-009 on each beat the accumulators SHALL update as follows:
- and_acc &= &in_data
- or_acc |= |in_data
- xor_acc ^= ^in_data
- len increments by 1, holding at all-ones.
REQ-010 on each beat, a word SHALL count as a parity error when (^in_data ^ in_par) != PARITY_ODD; par_acc ORs in this per-word error.
REQ-011 a beat with in_last=1 SHALL fold in that word and move to REPORT; out_valid rises on the next cycle, so latency from the last beat to the result is 1 cycle.
REQ-012 outputs out_and, out_or, out_xor, out_par_err and out_len SHALL show the accumulators and hold stable while out_valid=1 and out_ready=0.
REQ-013 a cycle in REPORT with out_ready=1 SHALL:
- complete the result handshake;
- reset the accumulators to and=1, or=0, xor=0, err=0, len=0;
- return to ACCUM.
The next word can be accepted on the following cycle.
REQ-014 a single-word frame (in_last on the first beat) SHALL report out_len=1 and the reductions of that one word.
REQ-015 out_ready asserted while in ACCUM SHALL have no effect.

Reset
REQ-016 while rst_n=0, the block SHALL hold the following values:
- state=ACCUM, in_ready=1, out_valid=0
- out_and=1, out_or=0, out_xor=0, out_par_err=0, out_len=0
- err_cnt=0
REQ-017 a reset asserted mid-frame or mid-REPORT SHALL discard the partial frame or pending result without emitting it.

Configuration
REQ-018 the macro PARITY_FRAME_ERR_CNT_EN SHALL control the error counter.
REQ-019 with the macro defined, the err_cnt port SHALL exist and count +1 on each result handshake with out_par_err=1, saturating at 16'hFFFF.
REQ-020 with the macro undefined, the err_cnt port and its register SHALL be absent; all other behaviour is unchanged.

Structure
REQ-021 a shared package parity_frame_pkg SHALL hold the state encoding (ACCUM=0, REPORT=1) and the parity-mode constants.
REQ-022 SHALL instantiate one sub-module, parity_word_check: combinational logic that takes one word and its parity bit and returns the word's AND, OR and XOR reductions plus its parity error.

Verification
REQ-023 the bench SHALL cover at least these scenarios (DATA_W=8, PARITY_ODD=0):
- Frame 8'hFF/par 0, 8'hFF/par 0 with last on beat 2 -> one cycle later out_valid=1, and=1, or=1, xor=0, par_err=0, len=2.
- Single word 8'h00/par 0 with last -> and=0, or=0, xor=0, par_err=0, len=1.
- Frame 8'h01/par 0, 8'h03/par 0 -> and=0, or=1, xor=1, par_err=1 (the first word fails); err_cnt=1 with the macro defined.
- out_ready held 0 for 5 cycles in REPORT -> in_ready=0, outputs stable, in_valid ignored; then out_ready=1 -> ACCUM on the next cycle.
- 300 words with no last (LEN_W=8) -> out_len holds 8'hFF once last arrives.
- rst_n pulled low after 3 beats of a frame -> no out_valid; the next frame reports len counted from 0.

Source files
------------

// File: rtl/parity_frame_pkg.sv
// Shared definitions for the parity frame checker: FSM state encoding,
// parity-mode constants and the per-word parity helper.
package parity_frame_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  localparam int PARITY_MODE_EVEN = 0;
  localparam int PARITY_MODE_ODD  = 1;

  // A word fails when data parity combined with the sent bit does not
  // match the selected mode (0 for even, 1 for odd).
  function automatic logic parity_fail(input logic data_xor,
                                       input logic par_bit,
                                       input logic odd_mode);
    return ((data_xor ^ par_bit) != odd_mode);
  endfunction

endpackage

// File: rtl/parity_word_check.sv
// Combinational per-word reductions and parity check for one data word.
module parity_word_check
  import parity_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic [DATA_W-1:0] word,
  input  logic              par,
  output logic              word_and,
  output logic              word_or,
  output logic              word_xor,
  output logic              word_par_err
);

  localparam logic ODD_MODE = (PARITY_ODD == PARITY_MODE_ODD) ? 1'b1 : 1'b0;

  // Reduce the word and compare its parity against the sent bit.
  always_comb begin
    word_and     = &word;
    word_or      = |word;
    word_xor     = ^word;
    word_par_err = parity_fail(^word, par, ODD_MODE);
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Parity frame checker: accumulates AND/OR/XOR reductions, parity errors
// and a saturating word count over a frame, then presents the result
// with a valid/ready handshake.
// Optional feature: define PARITY_FRAME_ERR_CNT_EN to add the err_cnt
// port, a saturating count of reported frames that carried a parity error.
module parity_frame_checker
  import parity_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_and,
  output logic              out_or,
  output logic              out_xor,
  output logic              out_par_err,
  output logic [LEN_W-1:0]  out_len
`ifdef PARITY_FRAME_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  state_t             state_r;
  state_t             state_next_s;
  logic               beat_s;
  logic               done_s;
  logic               and_acc_r;
  logic               or_acc_r;
  logic               xor_acc_r;
  logic               par_acc_r;
  logic [LEN_W-1:0]   len_r;
  logic               w_and_s;
  logic               w_or_s;
  logic               w_xor_s;
  logic               w_par_err_s;

  parity_word_check #(
    .DATA_W     (DATA_W),
    .PARITY_ODD (PARITY_ODD)
  ) u_word_check (
    .word         (in_data),
    .par          (in_par),
    .word_and     (w_and_s),
    .word_or      (w_or_s),
    .word_xor     (w_xor_s),
    .word_par_err (w_par_err_s)
  );

  // Handshake decode from the state register and next-state selection.
  always_comb begin
    state_next_s = state_r;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    beat_s       = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ACCUM: begin
        in_ready = 1'b1;
        beat_s   = in_valid;
        if (in_valid && in_last) begin
          state_next_s = REPORT;
        end else begin
          state_next_s = ACCUM;
        end
      end
      REPORT: begin
        out_valid = 1'b1;
        done_s    = out_ready;
        if (out_ready) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = REPORT;
        end
      end
      default: begin
        state_next_s = ACCUM;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Frame accumulators: fold in each beat, clear after the result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_acc_r <= 1'b1;
      or_acc_r  <= 1'b0;
      xor_acc_r <= 1'b0;
      par_acc_r <= 1'b0;
      len_r     <= {LEN_W{1'b0}};
    end else if (done_s) begin
      and_acc_r <= 1'b1;
      or_acc_r  <= 1'b0;
      xor_acc_r <= 1'b0;
      par_acc_r <= 1'b0;
      len_r     <= {LEN_W{1'b0}};
    end else if (beat_s) begin
      and_acc_r <= and_acc_r & w_and_s;
      or_acc_r  <= or_acc_r | w_or_s;
      xor_acc_r <= xor_acc_r ^ w_xor_s;
      par_acc_r <= par_acc_r | w_par_err_s;
      if (len_r != {LEN_W{1'b1}}) begin
        len_r <= len_r + {{(LEN_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_and     = and_acc_r;
  assign out_or      = or_acc_r;
  assign out_xor     = xor_acc_r;
  assign out_par_err = par_acc_r;
  assign out_len     = len_r;

`ifdef PARITY_FRAME_ERR_CNT_EN
  logic [15:0] err_cnt_r;

  // Count reported frames carrying a parity error, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 16'h0000;
    end else if (done_s && par_acc_r && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed self-checking bench for parity_frame_checker (DATA_W=8,
// LEN_W=8, even parity). Inputs change on the falling edge; outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_parity_frame_checker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_par;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic       out_and;
  logic       out_or;
  logic       out_xor;
  logic       out_par_err;
  logic [7:0] out_len;
`ifdef PARITY_FRAME_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  parity_frame_checker #(
    .DATA_W     (8),
    .LEN_W      (8),
    .PARITY_ODD (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_par      (in_par),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_and     (out_and),
    .out_or      (out_or),
    .out_xor     (out_xor),
    .out_par_err (out_par_err),
    .out_len     (out_len)
`ifdef PARITY_FRAME_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one word for one beat; returns at the following falling edge.
  task automatic send(input logic [7:0] d, input logic p, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    in_par   = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic a, input logic o,
                              input logic x, input logic pe, input logic [7:0] len);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_and"}, {31'd0, out_and}, {31'd0, a});
    check({tag, "_or"}, {31'd0, out_or}, {31'd0, o});
    check({tag, "_xor"}, {31'd0, out_xor}, {31'd0, x});
    check({tag, "_perr"}, {31'd0, out_par_err}, {31'd0, pe});
    check({tag, "_len"}, {24'd0, out_len}, {24'd0, len});
  endtask

  // Complete the result handshake and confirm return to ACCUM.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drained_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_drained_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_par    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_and", {31'd0, out_and}, 32'd1);
    check("rst_or", {31'd0, out_or}, 32'd0);
    check("rst_xor", {31'd0, out_xor}, 32'd0);
    check("rst_perr", {31'd0, out_par_err}, 32'd0);
    check("rst_len", {24'd0, out_len}, 32'd0);
`ifdef PARITY_FRAME_ERR_CNT_EN
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Frame FF, FF
    send(8'hFF, 1'b0, 1'b0);
    check("f1_mid_valid", {31'd0, out_valid}, 32'd0);
    send(8'hFF, 1'b0, 1'b1);
    check_result("f1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    check("f1_in_ready", {31'd0, in_ready}, 32'd0);
    drain("f1");

    // Single word 00
    send(8'h00, 1'b0, 1'b1);
    check_result("f2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    drain("f2");

    // Frame 01, 03: first word fails even parity
    send(8'h01, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b1);
    check_result("f3", 1'b0, 1'b1, 1'b1, 1'b1, 8'd2);
    drain("f3");
`ifdef PARITY_FRAME_ERR_CNT_EN
    check("f3_err_cnt", {16'd0, err_cnt}, 32'd1);
`endif

    // Stall in REPORT for 5 cycles with in_valid driven
    send(8'hA5, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h00;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check_result("stall", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain("stall");

    // out_ready while in ACCUM has no effect
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("accum_ready_valid", {31'd0, out_valid}, 32'd0);
    check("accum_ready_len", {24'd0, out_len}, 32'd0);
    send(8'h80, 1'b1, 1'b1);
    check_result("f5", 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
    drain("f5");

    // 300 words: length saturates
    for (int i = 0; i < 299; i++) begin
      send(8'hFF, 1'b0, 1'b0);
    end
    send(8'hFF, 1'b0, 1'b1);
    check_result("sat", 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    drain("sat");

    // Reset mid-frame discards the partial frame
    send(8'h0F, 1'b1, 1'b0);
    send(8'h0F, 1'b1, 1'b0);
    send(8'h0F, 1'b1, 1'b0);
    check("mid_len", {24'd0, out_len}, 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_len", {24'd0, out_len}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    send(8'h3C, 1'b0, 1'b0);
    send(8'h18, 1'b0, 1'b1);
    check_result("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    drain("post_rst");
`ifdef PARITY_FRAME_ERR_CNT_EN
    check("post_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
